// File: rtl/alu_issue_pkg.sv
// Shared types and encodings for the execute-stage ALU issue block.
// Holds the FSM state enum, funct encodings and the ALU drive bundle.
package alu_issue_pkg;

  localparam logic [6:0] FUNCT7_M   = 7'b0000001;
  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;
  localparam logic [6:0] FUNCT7_SRA = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    ISSUE,
    WAIT,
    RESULT,
    DRAIN
  } alu_issue_state_t;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
  } alu_op_t;

  // Drive seen by the ALU while SETTLE lets an orphaned divide finish.
  function automatic alu_op_t settle_op();
    alu_op_t op;
    op        = '0;
    op.funct3 = F3_DIVU;
    op.funct7 = FUNCT7_M;
    return op;
  endfunction

endpackage

// File: rtl/alu_issue.sv
// Issue/sequencing stage in front of the ALU: holds operands until done,
// then presents the result to writeback on a valid/ready handshake.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 34,
  parameter bit          ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic        in_is_imm,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_is_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        alu_ready,
  input  logic [31:0] alu_out,
  input  logic        alu_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int unsigned CW =
    (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  alu_issue_state_t state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  alu_op_t          drv;
  alu_op_t          acc_op;
  logic             accept;
  logic             suppress;
  logic             capture;

  assign in_ready = !flush &&
    (state == IDLE || (state == RESULT && wb_ready));
  assign accept   = in_valid && in_ready;
  assign suppress = ZERO_RD_SUPPRESS && (drv.rd == 5'd0);
  assign capture  = (state == ISSUE || state == WAIT) &&
    alu_done && !flush && !suppress;

  always_comb begin
    acc_op        = '0;
    acc_op.in1    = in_rs1_val;
    acc_op.in2    = in_is_imm ? in_imm : in_rs2_val;
    acc_op.is_imm = in_is_imm;
    acc_op.funct3 = in_funct3;
    acc_op.funct7 = in_funct7;
    acc_op.rd     = in_rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SETTLE;
      cnt   <= CW'(SETTLE_CYCLES);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      SETTLE: begin
        if (cnt != '0) cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) state_n = IDLE;
      end
      IDLE: begin
        if (accept) state_n = ISSUE;
      end
      ISSUE, WAIT: begin
        // A flush racing completion needs no drain: the ALU is already free.
        if (alu_done)
          state_n = (flush || suppress) ? IDLE : RESULT;
        else if (flush)
          state_n = DRAIN;
        else
          state_n = WAIT;
      end
      RESULT: begin
        if (flush)
          state_n = IDLE;
        else if (wb_ready)
          state_n = accept ? ISSUE : IDLE;
      end
      DRAIN: begin
        if (alu_done) state_n = IDLE;
      end
      default: state_n = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv     <= settle_op();
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (state == SETTLE)
        drv <= settle_op();
      else if (accept)
        drv <= acc_op;
      if (capture) begin
        wb_rd   <= drv.rd;
        wb_data <= alu_out;
      end
    end
  end

  assign alu_in1    = drv.in1;
  assign alu_in2    = drv.in2;
  assign alu_is_imm = drv.is_imm;
  assign alu_funct3 = drv.funct3;
  assign alu_funct7 = drv.funct7;

  assign alu_ready = (state == ISSUE);
  assign wb_valid  = (state == RESULT);
  assign busy      = (state == ISSUE) || (state == WAIT) ||
                     (state == RESULT) || (state == DRAIN);

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU stand-in
// (single-cycle ops done at once, divides done 33 cycles after start).
module tb_alu_issue;

  localparam logic [6:0] M7   = 7'b0000001;
  localparam logic [6:0] SUB7 = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic [31:0] in_imm = '0;
  logic        in_is_imm = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_in1, alu_in2, alu_out, wb_data;
  logic        alu_is_imm, alu_ready, alu_done;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        wb_valid, busy;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;
  int div_cnt = 0;

  alu_issue #(.SETTLE_CYCLES(34), .ZERO_RD_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_is_imm(in_is_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_is_imm(alu_is_imm),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_ready(alu_ready), .alu_out(alu_out), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic is_div(input logic [2:0] f3,
                                  input logic [6:0] f7);
    return (f7 == M7) && f3[2];
  endfunction

  // RV32IM arithmetic from the ISA definition.
  function automatic logic [31:0] ref_alu(input logic [31:0] a,
      input logic [31:0] b, input logic [2:0] f3,
      input logic [6:0] f7, input logic imm);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    logic signed [31:0] x, y;
    logic [31:0] r;
    x = a; y = b;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    r = '0;
    if (f7 == M7) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * ub; r = p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
        3'd4: if (b == 0) r = '1;
              else if (a == 32'h8000_0000 && b == '1) r = a;
              else r = x / y;
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: if (b == 0) r = a;
              else if (a == 32'h8000_0000 && b == '1) r = '0;
              else r = x % y;
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      case (f3)
        3'd0: r = (f7 == SUB7 && !imm) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = {31'b0, x < y};
        3'd3: r = {31'b0, a < b};
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'(x >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    alu_out  = ref_alu(alu_in1, alu_in2, alu_funct3, alu_funct7, alu_is_imm);
    alu_done = (alu_ready && !is_div(alu_funct3, alu_funct7)) ||
               (div_cnt == 1);
  end

  always @(posedge clk) begin
    if (alu_ready && is_div(alu_funct3, alu_funct7)) div_cnt <= 33;
    else if (div_cnt != 0) div_cnt <= div_cnt - 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge (the ISSUE cycle).
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic is_imm,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd);
    int n;
    in_rs1_val = a; in_rs2_val = b; in_imm = imm;
    in_is_imm = is_imm; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    while (!wb_valid && n < 80) begin tick(); n++; end
  endtask

  task automatic wait_settle(output int n, output bit bad);
    n = 0; bad = 0;
    while (!in_ready && n < 100) begin
      if (wb_valid || busy || alu_ready || alu_funct7 !== M7 ||
          alu_funct3 !== 3'b101 || alu_is_imm) bad = 1;
      tick(); n++;
    end
  endtask

  task automatic test_reset();
    int n; bit bad;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, wb_valid, in_ready, alu_ready, alu_is_imm} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
        {busy, wb_valid, in_ready, alu_ready, alu_is_imm});
    end
    checks++;
    if (alu_funct7 !== M7 || alu_funct3 !== 3'b101) begin
      errors++; $display("FAIL reset_funct: got %h/%h want 01/5",
        alu_funct7, alu_funct3);
    end
    checks++;
    if (wb_data !== 32'd0 || wb_rd !== 5'd0 || alu_in1 !== 32'd0) begin
      errors++; $display("FAIL reset_data: wb_data=%h wb_rd=%0d in1=%h want 0",
        wb_data, wb_rd, alu_in1);
    end
    rst = 1'b1;
    wait_settle(n, bad);
    checks++;
    if (n != 34) begin
      errors++; $display("FAIL settle_len: got %0d want 34", n);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL settle_outputs: bad=%0d want 0", bad);
    end
  endtask

  task automatic test_add();
    checks++;
    if (alu_ready !== 1'b1 || wb_valid !== 1'b0) begin end
    issue(32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 7'd0, 5'd3);
    checks++;
    if (alu_ready !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL add_issue: ready/valid/busy=%b%b%b want 101",
        alu_ready, wb_valid, busy);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd12 || wb_rd !== 5'd3) begin
      errors++; $display("FAIL add_result: v=%b data=%0d rd=%0d want 1 12 3",
        wb_valid, wb_data, wb_rd);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_idle: v=%b busy=%b want 0 0",
        wb_valid, busy);
    end
  endtask

  task automatic test_div();
    int n; bit bad;
    issue(32'(-20), 32'd3, 32'd0, 1'b0, 3'd4, M7, 5'd9);
    n = 0; bad = 0;
    while (!wb_valid && n < 80) begin
      if (alu_in1 !== 32'(-20) || alu_in2 !== 32'd3 || in_ready !== 1'b0 ||
          busy !== 1'b1 || (n > 0 && alu_ready)) bad = 1;
      tick(); n++;
    end
    checks++;
    if (n != 34) begin
      errors++; $display("FAIL div_latency: got %0d want 34", n);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL div_hold: operands/in_ready changed while waiting");
    end
    checks++;
    if (wb_data !== 32'(-6) || wb_rd !== 5'd9) begin
      errors++; $display("FAIL div_result: data=%h rd=%0d want fffffffa 9",
        wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit bad;
    wb_ready = 1'b0;
    issue(32'd10, 32'd20, 32'd0, 1'b0, 3'd0, 7'd0, 5'd5);
    tick();
    in_rs1_val = 32'h0F0F_0000; in_rs2_val = 32'h00FF_00FF;
    in_is_imm = 1'b0; in_funct3 = 3'd4; in_funct7 = 7'd0; in_rd = 5'd6;
    in_valid = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_valid !== 1'b1 || wb_data !== 32'd30 || wb_rd !== 5'd5 ||
          in_ready !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold: result not stable or op accepted");
    end
    wb_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || wb_data !== 32'd30) begin
      errors++; $display("FAIL bp_release: in_ready=%b data=%0d want 1 30",
        in_ready, wb_data);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (alu_ready !== 1'b1 || wb_valid !== 1'b0 ||
        alu_in1 !== 32'h0F0F_0000) begin
      errors++; $display("FAIL bp_same_cycle: ready=%b v=%b in1=%h want 1 0 0f0f0000",
        alu_ready, wb_valid, alu_in1);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0FF0_00FF || wb_rd !== 5'd6) begin
      errors++; $display("FAIL bp_second: v=%b data=%h rd=%0d want 1 0ff000ff 6",
        wb_valid, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_flush_result();
    wb_ready = 1'b0;
    issue(32'd1, 32'd2, 32'd0, 1'b0, 3'd0, 7'd0, 5'd7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_result: v=%b busy=%b want 0 0",
        wb_valid, busy);
    end
    wb_ready = 1'b1;
    issue(32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 7'd0, 5'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_issue_done: v=%b busy=%b want 0 0",
        wb_valid, busy);
    end
  endtask

  task automatic test_flush_drain();
    int n, lat; bit bad;
    issue(32'd100, 32'd7, 32'd0, 1'b0, 3'd5, M7, 5'd11);
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 60) begin
      if (wb_valid || in_ready || alu_ready || alu_in1 !== 32'd100) bad = 1;
      flush = (n == 2);
      tick(); n++;
    end
    flush = 1'b0;
    checks++;
    if (n != 30) begin
      errors++; $display("FAIL drain_len: got %0d want 30", n);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL drain_outputs: valid/ready seen during drain");
    end
    issue(32'd100, 32'd7, 32'd0, 1'b0, 3'd5, M7, 5'd12);
    wait_wb(lat);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd14 || wb_rd !== 5'd12) begin
      errors++; $display("FAIL divu_after_drain: v=%b data=%0d rd=%0d want 1 14 12",
        wb_valid, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_zero_rd();
    bit bad;
    issue(32'd1, $urandom, 32'd1, 1'b1, 3'd0, 7'd0, 5'd0);
    checks++;
    if (alu_in2 !== 32'd1 || alu_is_imm !== 1'b1) begin
      errors++; $display("FAIL zero_rd_imm: in2=%h imm=%b want 1 1",
        alu_in2, alu_is_imm);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_rd_idle: v=%b busy=%b rdy=%b want 0 0 1",
        wb_valid, busy, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL zero_rd_wb: wb_valid asserted for rd 0");
    end
  endtask

  task automatic test_reset_mid_div();
    int n; bit bad;
    issue(32'(-100), 32'd7, 32'd0, 1'b0, 3'd4, M7, 5'd4);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, wb_valid, alu_ready, in_ready} !== 4'b0 ||
        alu_funct7 !== M7 || alu_funct3 !== 3'b101 || alu_in1 !== 32'd0) begin
      errors++; $display("FAIL async_reset: flags=%b f7=%h f3=%h in1=%h",
        {busy, wb_valid, alu_ready, in_ready}, alu_funct7, alu_funct3, alu_in1);
    end
    tick();
    rst = 1'b1;
    wait_settle(n, bad);
    checks++;
    if (n != 34 || bad) begin
      errors++; $display("FAIL resettle: len=%0d bad=%0d want 34 0", n, bad);
    end
    issue(32'(-7), 32'd2, 32'd0, 1'b0, 3'd6, M7, 5'd6);
    wait_wb(n);
    checks++;
    if (n != 34 || wb_data !== 32'hFFFF_FFFF || wb_rd !== 5'd6) begin
      errors++; $display("FAIL rem_after_reset: lat=%0d data=%h rd=%0d want 34 ffffffff 6",
        n, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, b, imm, exp;
    logic [2:0] f3; logic [6:0] f7; logic [4:0] rd; logic is_imm;
    int kind, n, m, want; bit bad, r;
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      imm = $urandom;
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(1, 31));
      is_imm = (kind == 1);
      if (kind == 0)
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? SUB7 : 7'd0;
      else if (kind == 1)
        f7 = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? SUB7 : 7'd0;
      else
        f7 = M7;
      exp = ref_alu(a, is_imm ? imm : b, f3, f7, is_imm);
      want = is_div(f3, f7) ? 34 : 1;
      issue(a, b, imm, is_imm, f3, f7, rd);
      n = 0;
      while (!wb_valid && n < 80) begin
        wb_ready = 1'($urandom_range(0, 1));
        tick(); n++;
      end
      checks++;
      if (n != want || wb_data !== exp || wb_rd !== rd) begin
        errors++; $display("FAIL rand_%0d: lat=%0d data=%h rd=%0d want %0d %h %0d",
          t, n, wb_data, wb_rd, want, exp, rd);
      end
      m = 0; bad = 0;
      do begin
        r = (m == 19) ? 1'b1 : 1'($urandom_range(0, 1));
        wb_ready = r;
        if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== rd) bad = 1;
        tick(); m++;
      end while (!r);
      checks++;
      if (bad || wb_valid !== 1'b0) begin
        errors++; $display("FAIL rand_hs_%0d: bad=%0d v=%b want 0 0",
          t, bad, wb_valid);
      end
      wb_ready = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_back_to_back();
    test_flush_result();
    test_flush_drain();
    test_zero_rd();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
